// File: rtl/axi_aw_w_arbiter.sv
// Round-robin AW arbiter with a registered AW output and an order FIFO that
// steers whole W bursts to the shared port strictly in AW grant order.
module axi_aw_w_arbiter #(
  parameter int N_REQ       = 4,
  parameter int AW_WIDTH    = 64,
  parameter int W_WIDTH     = 72,
  parameter int MAX_PENDING = 4,
  localparam int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          slv_aw_valid_i,
  output logic [N_REQ-1:0]          slv_aw_ready_o,
  input  logic [N_REQ*AW_WIDTH-1:0] slv_aw_i,
  input  logic [N_REQ-1:0]          slv_w_valid_i,
  output logic [N_REQ-1:0]          slv_w_ready_o,
  input  logic [N_REQ*W_WIDTH-1:0]  slv_w_i,
  input  logic [N_REQ-1:0]          slv_w_last_i,
  output logic                      mst_aw_valid_o,
  input  logic                      mst_aw_ready_i,
  output logic [AW_WIDTH-1:0]       mst_aw_o,
  output logic [IDX_W-1:0]          mst_aw_sel_o,
  output logic                      mst_w_valid_o,
  input  logic                      mst_w_ready_i,
  output logic [W_WIDTH-1:0]        mst_w_o,
  output logic                      mst_w_last_o,
  output logic [CNT_W-1:0]          pending_o
);

  localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [PTR_W-1:0] ptr_t;

  logic [AW_WIDTH-1:0] aw_arr [N_REQ];
  logic [W_WIDTH-1:0]  w_arr  [N_REQ];

  logic                aw_vld_p1;
  logic [AW_WIDTH-1:0] aw_data_p1;
  idx_t                aw_sel_p1;
  idx_t                rr;

  idx_t       fifo_mem [MAX_PENDING];
  ptr_t       head;
  ptr_t       tail;
  logic [CNT_W-1:0] count;

  logic full;
  logic empty;
  logic load;
  logic push;
  logic pop;
  logic win_found;
  idx_t win_idx;
  idx_t cand;
  idx_t h;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(MAX_PENDING - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  function automatic idx_t idx_inc(input idx_t i);
    return (i == idx_t'(N_REQ - 1)) ? '0 : i + idx_t'(1);
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign aw_arr[g] = slv_aw_i[g*AW_WIDTH +: AW_WIDTH];
    assign w_arr[g]  = slv_w_i[g*W_WIDTH +: W_WIDTH];
  end

  assign full  = (count == CNT_W'(MAX_PENDING));
  assign empty = (count == '0);
  assign h     = fifo_mem[head];

  // Scan downward so the last hit is the first requester at or after rr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = idx_t'((int'(rr) + i) % N_REQ);
      if (slv_aw_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Full check uses the registered count, so a same-cycle pop cannot admit a grant.
  assign load = !rst_i && (!aw_vld_p1 || mst_aw_ready_i) && win_found && !full;
  assign push = load;
  assign pop  = mst_w_valid_o && mst_w_ready_i && mst_w_last_o;

  always_comb begin
    slv_aw_ready_o = '0;
    if (load) slv_aw_ready_o[win_idx] = 1'b1;
  end

  always_comb begin
    slv_w_ready_o = '0;
    mst_w_valid_o = 1'b0;
    mst_w_o       = '0;
    mst_w_last_o  = 1'b0;
    if (!empty) begin
      slv_w_ready_o[h] = mst_w_ready_i;
      mst_w_valid_o    = slv_w_valid_i[h];
      mst_w_o          = w_arr[h];
      mst_w_last_o     = slv_w_last_i[h];
    end
  end

  // Stage p1: AW output register, round-robin pointer and order FIFO control
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_vld_p1  <= 1'b0;
      aw_data_p1 <= '0;
      aw_sel_p1  <= '0;
      rr         <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      if (load) begin
        aw_vld_p1  <= 1'b1;
        aw_data_p1 <= aw_arr[win_idx];
        aw_sel_p1  <= win_idx;
        rr         <= idx_inc(win_idx);
      end else if (mst_aw_ready_i) begin
        aw_vld_p1  <= 1'b0;
      end
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[tail] <= win_idx;
  end

  assign mst_aw_valid_o = aw_vld_p1;
  assign mst_aw_o       = aw_data_p1;
  assign mst_aw_sel_o   = aw_sel_p1;
  assign pending_o      = count;

endmodule

// File: tb/tb_axi_aw_w_arbiter.sv
// Scoreboard bench for axi_aw_w_arbiter: directed AW/W traffic with expected
// grants, AW beats and W beats queued at issue time and popped by a monitor.
module tb_axi_aw_w_arbiter;
  localparam int N   = 4;
  localparam int AWW = 64;
  localparam int WW  = 72;
  localparam int MP  = 4;
  localparam int IW  = 2;
  localparam int CW  = 3;

  localparam logic [3:0] RR_GRANT [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  localparam logic [2:0] OW_PEND  [8] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0};
  localparam logic [3:0] OW_WRDY  [8] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h1, 4'h1, 4'h0};
  localparam logic [3:0] FF_GRANT [8] = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0, 4'h2};
  localparam logic [2:0] FF_PEND  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd3};
  localparam logic [3:0] SP_GRANT [4] = '{4'h4, 4'h8, 4'h0, 4'h0};
  localparam logic [2:0] SP_PEND  [4] = '{3'd0, 3'd1, 3'd1, 3'd0};
  localparam logic [3:0] SP_WRDY  [4] = '{4'h0, 4'h4, 4'h8, 4'h0};

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]     slv_aw_valid, slv_aw_ready, slv_w_valid, slv_w_ready, slv_w_last;
  logic [N*AWW-1:0] slv_aw;
  logic [N*WW-1:0]  slv_w;
  logic             mst_aw_valid, mst_aw_ready, mst_w_valid, mst_w_ready, mst_w_last;
  logic [AWW-1:0]   mst_aw;
  logic [IW-1:0]    mst_aw_sel;
  logic [WW-1:0]    mst_w;
  logic [CW-1:0]    pending;

  int n_checks = 0;
  int n_pass   = 0;

  logic [127:0] exp_grant[$];
  logic [127:0] exp_aw[$];
  logic [127:0] exp_w[$];

  int aw_todo [N];
  int aw_cnt  [N];
  int wcnt    [N];
  int w_beat  [N];
  int w_lenq  [N][$];
  logic [N-1:0] aw_hs = '0;
  logic [N-1:0] w_hs  = '0;

  axi_aw_w_arbiter #(.N_REQ(N), .AW_WIDTH(AWW), .W_WIDTH(WW), .MAX_PENDING(MP)) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_aw_valid_i(slv_aw_valid), .slv_aw_ready_o(slv_aw_ready), .slv_aw_i(slv_aw),
    .slv_w_valid_i(slv_w_valid), .slv_w_ready_o(slv_w_ready), .slv_w_i(slv_w),
    .slv_w_last_i(slv_w_last),
    .mst_aw_valid_o(mst_aw_valid), .mst_aw_ready_i(mst_aw_ready), .mst_aw_o(mst_aw),
    .mst_aw_sel_o(mst_aw_sel),
    .mst_w_valid_o(mst_w_valid), .mst_w_ready_i(mst_w_ready), .mst_w_o(mst_w),
    .mst_w_last_o(mst_w_last), .pending_o(pending)
  );

  always #5 clk = ~clk;

  function automatic logic [AWW-1:0] apl(input int k, input int n);
    return {8'(k), 8'(n), 48'h5A5A_0000_1234};
  endfunction

  function automatic logic [WW-1:0] wpl(input int k, input int j);
    return {8'(k), 8'(j), 56'hC3C3_0000_0000_77};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic note_fail(input string name, input int act);
    n_checks++;
    $display("FAIL %s: got %0d with nothing expected at %0t", name, act, $time);
  endtask

  task automatic exp_aw_push(input int k, input int n);
    exp_grant.push_back(128'(k));
    exp_aw.push_back(128'({IW'(k), apl(k, n)}));
  endtask

  task automatic exp_w_push(input int k, input int j, input logic last);
    exp_w.push_back(128'({wpl(k, j), last}));
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      slv_aw_valid[k] = (aw_todo[k] > 0);
      slv_aw[k*AWW +: AWW] = apl(k, aw_cnt[k]);
      if (w_lenq[k].size() > 0) begin
        slv_w_valid[k]     = 1'b1;
        slv_w[k*WW +: WW]  = wpl(k, wcnt[k]);
        slv_w_last[k]      = (w_beat[k] == w_lenq[k][0] - 1);
      end else begin
        slv_w_valid[k]     = 1'b0;
        slv_w[k*WW +: WW]  = '0;
        slv_w_last[k]      = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (aw_hs[k]) begin
        aw_todo[k]--;
        aw_cnt[k]++;
      end
      if (w_hs[k]) begin
        wcnt[k]++;
        w_beat[k]++;
        if (w_beat[k] == w_lenq[k][0]) begin
          void'(w_lenq[k].pop_front());
          w_beat[k] = 0;
        end
      end
    end
    drive();
  endtask

  task automatic clear_counts();
    for (int k = 0; k < N; k++) begin
      aw_cnt[k] = 0;
      wcnt[k]   = 0;
    end
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    logic busy;
    do begin
      tick();
      @(negedge clk);
      cyc++;
      busy = (exp_grant.size() > 0) || (exp_aw.size() > 0) || (exp_w.size() > 0);
      for (int k = 0; k < N; k++) busy = busy || (aw_todo[k] > 0) || (w_lenq[k].size() > 0);
    end while (busy && cyc < 60);
    if (busy) note_fail({name, "_drain_timeout"}, cyc);
    chk({name, "_pending_idle"}, 128'(pending), 128'(0));
  endtask

  // Monitor: record handshakes and check every transfer against the queues.
  always @(negedge clk) begin
    aw_hs = slv_aw_valid & slv_aw_ready;
    w_hs  = slv_w_valid & slv_w_ready;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        if (aw_hs[k]) begin
          if (exp_grant.size() == 0) note_fail("aw_grant_extra", k);
          else chk("aw_grant", 128'(k), exp_grant.pop_front());
        end
      end
      if (mst_aw_valid && mst_aw_ready) begin
        if (exp_aw.size() == 0) note_fail("mst_aw_extra", int'(mst_aw_sel));
        else chk("mst_aw", 128'({mst_aw_sel, mst_aw}), exp_aw.pop_front());
      end
      if (mst_w_valid && mst_w_ready) begin
        if (exp_w.size() == 0) note_fail("mst_w_extra", int'(mst_w_last));
        else chk("mst_w", 128'({mst_w, mst_w_last}), exp_w.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    mst_aw_ready = 1'b1;
    mst_w_ready  = 1'b1;
    slv_aw_valid = '0;
    slv_aw       = '0;
    slv_w_valid  = '0;
    slv_w        = '0;
    slv_w_last   = '0;

    // Reset with every valid high, then first grant to requester 0
    for (int k = 0; k < N; k++) begin
      aw_todo[k] = 1;
      w_lenq[k].push_back(1);
      exp_aw_push(k, 0);
      exp_w_push(k, 0, 1'b1);
    end
    drive();
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("reset_ctrl", 128'({slv_aw_ready, slv_w_ready, mst_aw_valid, mst_w_valid, pending,
                              mst_aw_sel, mst_w_last}), 128'(0));
    end
    chk("reset_aw_payload", 128'(mst_aw), 128'(0));
    chk("reset_w_payload", 128'(mst_w), 128'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("first_grant", 128'(slv_aw_ready), 128'(4'h1));
    wait_drain("reset");

    // Round-robin with all requesters valid
    tick();
    clear_counts();
    aw_todo = '{2, 1, 1, 1};
    for (int k = 0; k < N; k++) w_lenq[k].push_back(1);
    w_lenq[0].push_back(1);
    exp_aw_push(0, 0); exp_aw_push(1, 0); exp_aw_push(2, 0); exp_aw_push(3, 0); exp_aw_push(0, 1);
    exp_w_push(0, 0, 1'b1); exp_w_push(1, 0, 1'b1); exp_w_push(2, 0, 1'b1);
    exp_w_push(3, 0, 1'b1); exp_w_push(0, 1, 1'b1);
    drive();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr_grant", 128'(slv_aw_ready), 128'(RR_GRANT[i]));
      tick();
    end
    wait_drain("rr");

    // AW backpressure holds the register stable
    tick();
    clear_counts();
    mst_aw_ready = 1'b0;
    aw_todo[1] = 1;
    aw_todo[2] = 1;
    w_lenq[1].push_back(1);
    w_lenq[2].push_back(1);
    exp_aw_push(1, 0); exp_aw_push(2, 0);
    exp_w_push(1, 0, 1'b1); exp_w_push(2, 0, 1'b1);
    drive();
    @(negedge clk);
    chk("bp_first_grant", 128'(slv_aw_ready), 128'(4'h2));
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("bp_no_grant", 128'(slv_aw_ready), 128'(4'h0));
      chk("bp_hold", 128'({mst_aw_valid, mst_aw_sel, mst_aw}), 128'({1'b1, 2'd1, apl(1, 0)}));
    end
    tick();
    mst_aw_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume", 128'(slv_aw_ready), 128'(4'h4));
    wait_drain("bp");

    // W bursts follow AW grant order
    tick();
    clear_counts();
    aw_todo[2] = 1;
    w_lenq[2].push_back(4);
    w_lenq[0].push_back(2);
    exp_aw_push(2, 0); exp_aw_push(0, 0);
    for (int j = 0; j < 4; j++) exp_w_push(2, j, logic'(j == 3));
    exp_w_push(0, 0, 1'b0); exp_w_push(0, 1, 1'b1);
    drive();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("ow_pending", 128'(pending), 128'(OW_PEND[i]));
      chk("ow_wready", 128'(slv_w_ready), 128'(OW_WRDY[i]));
      tick();
      if (i == 0) begin
        aw_todo[0] = 1;
        drive();
      end
    end
    wait_drain("ow");

    // Order FIFO full blocks grants until the cycle after a pop
    tick();
    clear_counts();
    aw_todo = '{1, 2, 1, 1};
    exp_aw_push(1, 0); exp_aw_push(2, 0); exp_aw_push(3, 0); exp_aw_push(0, 0); exp_aw_push(1, 1);
    exp_w_push(1, 0, 1'b1); exp_w_push(2, 0, 1'b1); exp_w_push(3, 0, 1'b1);
    exp_w_push(0, 0, 1'b1); exp_w_push(1, 1, 1'b1);
    drive();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("ff_grant", 128'(slv_aw_ready), 128'(FF_GRANT[i]));
      chk("ff_pending", 128'(pending), 128'(FF_PEND[i]));
      tick();
      if (i == 5) begin
        w_lenq[1].push_back(1);
        drive();
      end
    end
    w_lenq[2].push_back(1);
    w_lenq[3].push_back(1);
    w_lenq[0].push_back(1);
    w_lenq[1].push_back(1);
    drive();
    wait_drain("ff");

    // Push and pop in the same cycle
    tick();
    clear_counts();
    aw_todo[2] = 1;
    exp_aw_push(2, 0); exp_aw_push(3, 0);
    exp_w_push(2, 0, 1'b1); exp_w_push(3, 0, 1'b1);
    drive();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sp_grant", 128'(slv_aw_ready), 128'(SP_GRANT[i]));
      chk("sp_pending", 128'(pending), 128'(SP_PEND[i]));
      chk("sp_wready", 128'(slv_w_ready), 128'(SP_WRDY[i]));
      tick();
      if (i == 0) begin
        aw_todo[3] = 1;
        w_lenq[2].push_back(1);
        w_lenq[3].push_back(1);
        drive();
      end
    end
    wait_drain("sp");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/axi_aw_w_arbiter.md
# axi_aw_w_arbiter

Round-robin arbiter that shares one AXI4 write address (AW) and write data (W) channel pair among N_REQ requesters. It sits in front of a shared downstream port, typically a register-cut stage. AW beats are granted round-robin and registered. W bursts are then routed strictly in AW grant order through an internal order FIFO, so W data never interleaves across bursts. The B response path is out of scope; the downstream uses `mst_aw_sel_o` to extend the ID.

## Interface
- N_REQ, 4, number of requesters (≥2)
- AW_WIDTH, 64, packed AW payload width (id/addr/len/size/burst/…/atop/user)
- W_WIDTH, 72, packed W payload width excluding last (data/strb/user)
- MAX_PENDING, 4, order-FIFO depth: bursts granted on AW whose W last beat has not yet transferred (≥1)
- IDX_W = max(1, $clog2(N_REQ)); CNT_W = $clog2(MAX_PENDING+1) (derived, not overridable)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- slv_aw_valid_i  in  N_REQ  per-requester AW valid
- slv_aw_ready_o  out  N_REQ  per-requester AW ready
- slv_aw_i  in  N_REQ*AW_WIDTH  AW payloads, requester k at [k*AW_WIDTH +: AW_WIDTH]
- slv_w_valid_i  in  N_REQ  per-requester W valid
- slv_w_ready_o  out  N_REQ  per-requester W ready
- slv_w_i  in  N_REQ*W_WIDTH  W payloads, same slicing
- slv_w_last_i  in  N_REQ  per-requester W last
- mst_aw_valid_o  out  1  shared AW valid (registered)
- mst_aw_ready_i  in  1  shared AW ready
- mst_aw_o  out  AW_WIDTH  registered AW payload
- mst_aw_sel_o  out  IDX_W  index of the requester owning mst_aw_o
- mst_w_valid_o  out  1  shared W valid
- mst_w_ready_i  in  1  shared W ready
- mst_w_o  out  W_WIDTH  W payload of the current W owner
- mst_w_last_o  out  1  W last of the current W owner
- pending_o  out  CNT_W  order-FIFO occupancy

## Operation
- AW stage has a one-entry output register with a valid flag.
  - `load` occurs when the register is empty, or is being drained this cycle (mst_aw_valid_o & mst_aw_ready_i), AND any slv_aw_valid_i is set AND the order FIFO is not full (registered count < MAX_PENDING).
- Arbitration on load:
  - The winner is the first set slv_aw_valid_i at or after pointer `rr`, searching upward modulo N_REQ.
  - slv_aw_ready_o[winner]=1 in that cycle only. All other AW readies are 0.
  - Payload and index are captured into mst_aw_o / mst_aw_sel_o. The winner index is pushed into the order FIFO.
  - `rr` ← (winner+1) mod N_REQ.
- While mst_aw_valid_o=1 and mst_aw_ready_i=0, mst_aw_o and mst_aw_sel_o are held stable (AXI rule). valid never drops without a handshake.
- W routing (combinational from the FIFO head `h`):
  - mst_w_valid_o = !empty & slv_w_valid_i[h].
  - slv_w_ready_o[h] = !empty & mst_w_ready_i. All other W readies are 0.
  - mst_w_o and mst_w_last_o are taken from requester h. They are 0 when the FIFO is empty.
- Pop occurs on a W handshake with last=1; the next burst owner becomes the head on the following cycle.
- Push and pop in the same cycle leave the count unchanged. The head and tail pointers wrap modulo MAX_PENDING.
- A requester's W data is blocked until its AW has been granted. This is legal for an AXI slave port.
- pending_o equals the FIFO count, including the entry for an AW still sitting in the output register.

## Timing
- Reset (rst_i=1 at a clock edge):
  - mst_aw_valid_o=0, mst_aw_o=0, mst_aw_sel_o=0, pending_o=0, rr=0, FIFO empty.
  - Hence mst_w_valid_o=0, all slv_*_ready_o=0, mst_w_o=0, mst_w_last_o=0.
  - Reset mid-burst discards all state, including AW held in the register and partially sent W bursts.
- AW latency: 1 cycle from slv_aw handshake to mst_aw_valid_o.
- AW throughput: 1 per cycle (reload in the same cycle as drain).
- W latency: 0 cycles; combinational pass-through once the owner is at the head.
- First W beat: transfers no earlier than the cycle after its AW grant (FIFO push is registered).
- FIFO full: no AW grants. A pop in the same cycle does not unblock the grant; the grant happens on the next cycle.
- Paths:
  - No combinational path from mst_aw_ready_i to any slv_aw_ready_o beyond the drain term.
  - W ready/valid are combinational through the block; place a cut downstream if needed.

## Test plan
- **Reset values:** hold rst_i 3 cycles with all valids high → all ready/valid outputs 0 and pending_o=0 throughout; first grant goes to requester 0 on the cycle after rst_i falls.
- **Round-robin:** N_REQ=4, all four AW valid continuously, mst_aw_ready_i=1 → grants in order 0,1,2,3,0; one per cycle; mst_aw_sel_o follows one cycle later.
- **Backpressure:** mst_aw_ready_i=0 for 5 cycles after the first AW → mst_aw_o/sel stable and valid held; no further slv_aw_ready_o; grant resumes the cycle ready rises.
- **Ordered W:** grant requester 2 (len=3), then requester 0 (len=1); both present W immediately → 4 beats from requester 2 then 2 from requester 0; requester 0's w_ready stays 0 until requester 2's last handshake; pending_o goes 2→1→0.
- **Full FIFO:** MAX_PENDING=4, issue 4 AWs with W withheld → 5th AW not granted and pending_o=4; completing one W burst (last handshake) → 5th AW granted the next cycle.
- **Simultaneous push/pop:** AW grant in the same cycle as a W last handshake → pending_o unchanged; the new owner is served in correct order.
